bus_regfile_ctrl: RTL and testbench
===================================

// Module: bus_regfile_ctrl
// PURPOSE
//  Bus-reader/controller end of the 16-bit CPU datapath. Holds R0..R7 plus ALU regs A and G.
//  Captures values from the shared bus (buswires). Sequences mv/mvi/add/sub instructions.
//  Drives the select lines (rout, din_en, gout) of the bus multiplexer.
//  Its aluout output (G) feeds that mux.
// PARAMETERS
//  DW      16   datapath/register width
//  IW       9   instruction width: [8:6]=opcode III, [5:3]=Rx, [2:0]=Ry
// PORTS
//  clk       in   1    rising-edge clock
//  resetn    in   1    asynchronous active-low reset
//  run       in   1    start request; sampled only in state T0
//  din       in   DW   instruction (in T0) / immediate (mvi T1)
//  buswires  in   DW   shared bus value from the mux
//  r0..r7    out  DW   register contents, to mux inputs
//  aluout    out  DW   G register, to mux
//  rout      out  3    mux register select
//  din_en    out  1    mux: 0=register path, 1=din/aluout path
//  gout      out  1    mux: 0=din, 1=aluout
//  done      out  1    high during the last step of an instruction
// BEHAVIOUR
//  Reset: r0..r7, A, G, IR = 0; state=T0; rout=0, din_en=0, gout=0, done=0.
//   Reset is async: it aborts any instruction immediately, and no partial write completes.
//  FSM states: T0,T1,T2,T3. Selects and done are combinational from state/IR.
//   All registers are flops.
//  T0: if run, then IR<=din[IW-1:0] and go to T1; else stay in T0. No bus load in T0.
//  Opcodes: 000 mv  | 001 mvi | 010 add | 011 sub | 100 and (macro) | others = NOP.
//  mv   T1: rout=Ry, din_en=0; Rx<=buswires; done=1 -> T0. 2 cycles.
//  mvi  T1: din_en=1, gout=0; Rx<=buswires (=din); done=1 -> T0. 2 cycles.
//  add  T1: rout=Rx, A<=buswires.
//       T2: rout=Ry, G<=A+buswires, modulo 2^DW with carry dropped.
//       T3: din_en=1, gout=1; Rx<=buswires (=G); done=1 -> T0. 4 cycles.
//  sub  Same as add, but T2 computes G<=A-buswires (two's-complement wrap, no borrow out).
//  NOP  T1: done=1, no register writes -> T0.
//  run is ignored outside T0; asserting run during T3 does not start a new fetch until T0.
//  Rx==Ry is legal: mv is a self-copy, and add R1,R1 doubles the value.
//  Only one register is written per cycle. r* outputs update the cycle after done.
//  When selects are unused: rout=0, din_en=0, gout=0.
// CONFIGURATION
//  AND_OP_EN defined: opcode 100 = and, executing the add sequence with G<=A&buswires.
//  AND_OP_EN undefined: opcode 100 is a NOP (2 cycles, no writes).
// STRUCTURE
//  cpu_pkg holds:
//   - opcode localparams (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND);
//   - state encodings T0..T3;
//   - DW/IW defaults.
//  Sub-module reg_en: DW-bit flop with enable and async active-low clear.
//   Ten instances: R0..R7, A, G; IR uses IW width.
//  The bench instantiates mux10_16bit so that the bus loop closes.
// TESTING
//  1. Reset mid-add (T2) -> all regs 0, state T0, done=0, selects 0.
//  2. mvi R2,#0x1234 (din=9'b001_010_000, then 0x1234) -> done in cycle 2, r2=0x1234.
//  3. mv R5,R2 -> rout=2 in T1, r5=0x1234 after done, r2 unchanged.
//  4. R0=0xFFFF, R1=0x0002; add R0,R1 -> r0=0x0001 (wrap), done on 4th cycle.
//  5. R3=0x0000, R4=0x0001; sub R3,R4 -> r3=0xFFFF.
//     Also hold run=1 across the whole op: the next fetch happens only in T0.
//  6. Opcode 100 with R6=0x0F0F, R7=0x00FF:
//     with AND_OP_EN, r6=0x000F after 4 cycles;
//     without it, done in T1 and r6 unchanged.
//     Opcode 111 is always a 2-cycle NOP.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit CPU datapath controller.
// Opcode 100 (and) is only decoded when the AND_OP_EN macro is defined.
package cpu_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int IW_DEFAULT = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

endpackage

// File: rtl/mux10_16bit.sv
// Shared bus multiplexer: selects one of R0..R7, din or the ALU result G.
// din_en=0 picks register rout; din_en=1 picks din (gout=0) or G (gout=1).
module mux10_16bit (
  input  logic [15:0] r0,
  input  logic [15:0] r1,
  input  logic [15:0] r2,
  input  logic [15:0] r3,
  input  logic [15:0] r4,
  input  logic [15:0] r5,
  input  logic [15:0] r6,
  input  logic [15:0] r7,
  input  logic [15:0] din,
  input  logic [15:0] g,
  input  logic [2:0]  rout,
  input  logic        din_en,
  input  logic        gout,
  output logic [15:0] bus
);

  always_comb begin
    bus = r0;
    if (din_en) begin
      bus = gout ? g : din;
    end else begin
      case (rout)
        3'd0:    bus = r0;
        3'd1:    bus = r1;
        3'd2:    bus = r2;
        3'd3:    bus = r3;
        3'd4:    bus = r4;
        3'd5:    bus = r5;
        3'd6:    bus = r6;
        default: bus = r7;
      endcase
    end
  end

endmodule

// File: rtl/reg_en.sv
// Generic W-bit register with load enable and asynchronous active-low clear.
// Used for R0..R7, A, G and the instruction register.
module reg_en #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bus_regfile_ctrl.sv
// Register file (R0..R7, A, G, IR) and T0..T3 sequencer for mv/mvi/add/sub.
// Define AND_OP_EN to make opcode 100 an and instruction; otherwise it is a NOP.
module bus_regfile_ctrl
  import cpu_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int IW = IW_DEFAULT
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          run,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] buswires,
  output logic [DW-1:0] r0,
  output logic [DW-1:0] r1,
  output logic [DW-1:0] r2,
  output logic [DW-1:0] r3,
  output logic [DW-1:0] r4,
  output logic [DW-1:0] r5,
  output logic [DW-1:0] r6,
  output logic [DW-1:0] r7,
  output logic [DW-1:0] aluout,
  output logic [2:0]    rout,
  output logic          din_en,
  output logic          gout,
  output logic          done
);

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] ir_q;
  logic [2:0]    opcode;
  logic [2:0]    rx;
  logic [2:0]    ry;
  logic          is_alu;
  logic          ir_load;
  logic          rx_write;
  logic [7:0]    reg_wen;
  logic          a_load;
  logic          g_load;
  logic [DW-1:0] a_q;
  logic [DW-1:0] alu_res;
  logic [DW-1:0] reg_q [8];
  logic          unused_din_hi;

  assign unused_din_hi = ^din[DW-1:IW];

  assign opcode = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

`ifdef AND_OP_EN
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);
`else
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
`endif

  // State register: reset drops straight back to T0, abandoning any instruction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: single-step instructions return from T1; ALU ops walk T1-T2-T3.
  always_comb begin
    state_d = state_q;
    case (state_q)
      T0:      if (run) state_d = T1;
      T1:      state_d = is_alu ? T2 : T0;
      T2:      state_d = T3;
      T3:      state_d = T0;
      default: state_d = T0;
    endcase
  end

  // Mux selects and done; everything idles at zero when the bus is not in use.
  always_comb begin
    rout   = 3'd0;
    din_en = 1'b0;
    gout   = 1'b0;
    done   = 1'b0;
    case (state_q)
      T1: begin
        if (opcode == OP_MV) begin
          rout = ry;
          done = 1'b1;
        end else if (opcode == OP_MVI) begin
          din_en = 1'b1;
          done   = 1'b1;
        end else if (is_alu) begin
          rout = rx;
        end else begin
          done = 1'b1;
        end
      end
      T2: rout = ry;
      T3: begin
        din_en = 1'b1;
        gout   = 1'b1;
        done   = 1'b1;
      end
      default: ;
    endcase
  end

  // At most one of IR, Rx, A or G loads in any given state.
  assign ir_load  = (state_q == T0) && run;
  assign a_load   = (state_q == T1) && is_alu;
  assign g_load   = (state_q == T2);
  assign rx_write = ((state_q == T1) && ((opcode == OP_MV) || (opcode == OP_MVI)))
                  || (state_q == T3);

  always_comb begin
    reg_wen = 8'd0;
    if (rx_write) begin
      reg_wen[rx] = 1'b1;
    end
  end

  // Carry and borrow fall off the top; results wrap modulo 2^DW.
  always_comb begin
    alu_res = a_q + buswires;
    case (opcode)
      OP_SUB:  alu_res = a_q - buswires;
`ifdef AND_OP_EN
      OP_AND:  alu_res = a_q & buswires;
`endif
      default: alu_res = a_q + buswires;
    endcase
  end

  reg_en #(.W(IW)) u_ir (
    .clk    (clk),
    .resetn (resetn),
    .en     (ir_load),
    .d      (din[IW-1:0]),
    .q      (ir_q)
  );

  for (genvar i = 0; i < 8; i++) begin : g_regs
    reg_en #(.W(DW)) u_reg (
      .clk    (clk),
      .resetn (resetn),
      .en     (reg_wen[i]),
      .d      (buswires),
      .q      (reg_q[i])
    );
  end

  reg_en #(.W(DW)) u_a (
    .clk    (clk),
    .resetn (resetn),
    .en     (a_load),
    .d      (buswires),
    .q      (a_q)
  );

  reg_en #(.W(DW)) u_g (
    .clk    (clk),
    .resetn (resetn),
    .en     (g_load),
    .d      (alu_res),
    .q      (aluout)
  );

  assign r0 = reg_q[0];
  assign r1 = reg_q[1];
  assign r2 = reg_q[2];
  assign r3 = reg_q[3];
  assign r4 = reg_q[4];
  assign r5 = reg_q[5];
  assign r6 = reg_q[6];
  assign r7 = reg_q[7];

endmodule

// File: tb/tb_bus_regfile_ctrl.sv
// Bench for bus_regfile_ctrl with the bus mux closing the loop.
// An instruction-level model predicts outputs; one negedge process compares them.
module tb_bus_regfile_ctrl;

`ifdef AND_OP_EN
  localparam bit AND_EN = 1'b1;
`else
  localparam bit AND_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic [15:0] buswires;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] aluout;
  logic [2:0]  rout;
  logic        din_en;
  logic        gout;
  logic        done;

  logic [15:0] dut_r [8];
  logic [15:0] exp_r [8];
  logic [15:0] exp_g;
  logic [2:0]  exp_rout;
  logic        exp_din_en;
  logic        exp_gout;
  logic        exp_done;
  bit          chk_on;

  bit          busy;
  int          lat_cnt;
  int          last_lat;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bus_regfile_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .run      (run),
    .din      (din),
    .buswires (buswires),
    .r0       (r0),
    .r1       (r1),
    .r2       (r2),
    .r3       (r3),
    .r4       (r4),
    .r5       (r5),
    .r6       (r6),
    .r7       (r7),
    .aluout   (aluout),
    .rout     (rout),
    .din_en   (din_en),
    .gout     (gout),
    .done     (done)
  );

  mux10_16bit u_mux (
    .r0     (r0),
    .r1     (r1),
    .r2     (r2),
    .r3     (r3),
    .r4     (r4),
    .r5     (r5),
    .r6     (r6),
    .r7     (r7),
    .din    (din),
    .g      (aluout),
    .rout   (rout),
    .din_en (din_en),
    .gout   (gout),
    .bus    (buswires)
  );

  always_comb begin
    dut_r[0] = r0;
    dut_r[1] = r1;
    dut_r[2] = r2;
    dut_r[3] = r3;
    dut_r[4] = r4;
    dut_r[5] = r5;
    dut_r[6] = r6;
    dut_r[7] = r7;
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Every cycle: compare all outputs with the model; also time each instruction.
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("done", {15'd0, done}, {15'd0, exp_done});
      checkOutput("rout", {13'd0, rout}, {13'd0, exp_rout});
      checkOutput("din_en", {15'd0, din_en}, {15'd0, exp_din_en});
      checkOutput("gout", {15'd0, gout}, {15'd0, exp_gout});
      checkOutput("aluout", aluout, exp_g);
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("r%0d", i), dut_r[i], exp_r[i]);
      end
    end
    if (busy) begin
      lat_cnt++;
    end else if (resetn && run) begin
      busy    = 1'b1;
      lat_cnt = 1;
    end
    if (busy && done) begin
      last_lat = lat_cnt;
      busy     = 1'b0;
    end
  end

  task automatic setIdle();
    exp_done   = 1'b0;
    exp_rout   = 3'd0;
    exp_din_en = 1'b0;
    exp_gout   = 1'b0;
  endtask

  task automatic clearModel();
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    exp_g = 16'h0000;
    setIdle();
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction from T0; imm is driven on din after the fetch cycle.
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                               input logic [15:0] imm, input bit hold_run);
    logic [15:0] res;
    bit          alu;
    alu = (op == 3'b010) || (op == 3'b011) || ((op == 3'b100) && AND_EN);
    run = 1'b1;
    din = {7'd0, op, rx, ry};
    setIdle();
    nextCycle();
    run = hold_run;
    din = imm;
    if (op == 3'b000) begin
      exp_rout = ry;
      exp_done = 1'b1;
      nextCycle();
      exp_r[rx] = exp_r[ry];
    end else if (op == 3'b001) begin
      exp_din_en = 1'b1;
      exp_done   = 1'b1;
      nextCycle();
      exp_r[rx] = imm;
    end else if (alu) begin
      case (op)
        3'b010:  res = exp_r[rx] + exp_r[ry];
        3'b011:  res = exp_r[rx] - exp_r[ry];
        default: res = exp_r[rx] & exp_r[ry];
      endcase
      exp_rout = rx;
      nextCycle();
      exp_rout = ry;
      nextCycle();
      exp_g      = res;
      exp_rout   = 3'd0;
      exp_din_en = 1'b1;
      exp_gout   = 1'b1;
      exp_done   = 1'b1;
      nextCycle();
      exp_r[rx] = res;
    end else begin
      exp_done = 1'b1;
      nextCycle();
    end
    setIdle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn   = 1'b0;
    run      = 1'b0;
    din      = 16'h0000;
    busy     = 1'b0;
    lat_cnt  = 0;
    last_lat = 0;
    clearModel();
    chk_on   = 1'b1;
    nextCycle();
    nextCycle();
    resetn = 1'b1;
    nextCycle();
    $display("[TB] reset state checked, starting instructions");

    // mvi R2,#0x1234
    applyStimulus(3'b001, 3'd2, 3'd0, 16'h1234, 1'b0);
    checkOutput("mvi_r2", r2, 16'h1234);
    checkOutput("mvi_latency", last_lat[15:0], 16'd2);

    // mv R5,R2
    applyStimulus(3'b000, 3'd5, 3'd2, 16'h0041, 1'b0);
    checkOutput("mv_r5", r5, 16'h1234);
    checkOutput("mv_r2_kept", r2, 16'h1234);
    checkOutput("mv_latency", last_lat[15:0], 16'd2);

    // add R0,R1 with wraparound
    applyStimulus(3'b001, 3'd0, 3'd0, 16'hFFFF, 1'b0);
    applyStimulus(3'b001, 3'd1, 3'd0, 16'h0002, 1'b0);
    applyStimulus(3'b010, 3'd0, 3'd1, 16'h0000, 1'b0);
    checkOutput("add_wrap_r0", r0, 16'h0001);
    checkOutput("add_latency", last_lat[15:0], 16'd4);

    // sub R3,R4 with run held high and a distracting mvi R7 on din
    applyStimulus(3'b001, 3'd3, 3'd0, 16'h0000, 1'b0);
    applyStimulus(3'b001, 3'd4, 3'd0, 16'h0001, 1'b0);
    applyStimulus(3'b011, 3'd3, 3'd4, 16'h0078, 1'b1);
    checkOutput("sub_wrap_r3", r3, 16'hFFFF);
    checkOutput("sub_r7_untouched", r7, 16'h0000);
    applyStimulus(3'b000, 3'd6, 3'd3, 16'h0000, 1'b0);
    checkOutput("mv_after_hold_r6", r6, 16'hFFFF);

    // Rx==Ry: doubling and self-copy
    applyStimulus(3'b010, 3'd1, 3'd1, 16'h0000, 1'b0);
    checkOutput("add_double_r1", r1, 16'h0004);
    applyStimulus(3'b000, 3'd2, 3'd2, 16'h0000, 1'b0);
    checkOutput("mv_self_r2", r2, 16'h1234);

    // opcode 100: and when enabled, otherwise a 2-cycle NOP
    applyStimulus(3'b001, 3'd6, 3'd0, 16'h0F0F, 1'b0);
    applyStimulus(3'b001, 3'd7, 3'd0, 16'h00FF, 1'b0);
    applyStimulus(3'b100, 3'd6, 3'd7, 16'h0000, 1'b0);
    checkOutput("op100_r6", r6, AND_EN ? 16'h000F : 16'h0F0F);
    checkOutput("op100_latency", last_lat[15:0], AND_EN ? 16'd4 : 16'd2);

    // opcode 111 is always a NOP
    applyStimulus(3'b111, 3'd7, 3'd6, 16'h0000, 1'b0);
    checkOutput("nop_r7", r7, 16'h00FF);
    checkOutput("nop_latency", last_lat[15:0], 16'd2);

    // Reset while an add R6,R7 sits in T2
    run = 1'b1;
    din = {7'd0, 3'b010, 3'd6, 3'd7};
    setIdle();
    nextCycle();
    run = 1'b0;
    exp_rout = 3'd6;
    nextCycle();
    exp_rout = 3'd7;
    #2;
    resetn = 1'b0;
    busy   = 1'b0;
    clearModel();
    nextCycle();
    checkOutput("rst_r6", r6, 16'h0000);
    checkOutput("rst_g", aluout, 16'h0000);
    checkOutput("rst_done", {15'd0, done}, 16'd0);
    resetn = 1'b1;
    nextCycle();

    // Recovery after the abort
    applyStimulus(3'b001, 3'd4, 3'd0, 16'hBEEF, 1'b0);
    checkOutput("post_rst_r4", r4, 16'hBEEF);
    nextCycle();

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
